// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: value/load inputs and scanned outputs.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_en;
  logic                lz_suppress;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel;
  logic                frame_done;

  modport master (
    output data, dp, digit_en, lz_suppress, load,
    input  seg, sel, frame_done
  );

  modport slave (
    input  data, dp, digit_en, lz_suppress, load,
    output seg, sel, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-segment 7-segment driver: slot counter scan, dead-time blanking,
// leading-zero suppression and double-buffered frame-boundary updates.
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCAN_DIV       = 125000,
  parameter int unsigned BLANK_CYC      = 2500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  seg7_scan_driver_if.slave    disp_io
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = $clog2(DIGITS);

  localparam logic [7:0]        SegOff = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SelOff = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   en;
    logic                lz;
  } disp_t;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  disp_t             pend_q, pend_d;
  disp_t             act_q, act_d;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              fdone_q, fdone_d;

  logic              slot_end;
  logic              frame_end;
  logic              blank;
  logic [DIGITS-1:0] zero_above;
  logic              all_zero;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_en;
  logic              cur_supp;
  logic [7:0]        seg_raw;
  logic [DIGITS-1:0] sel_raw;

  // Scan timebase and display double buffer.
  always_comb begin
    slot_end  = (cnt_q == CntW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IdxW'(DIGITS - 1));

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    if (frame_end && pend_vld_q) begin
      act_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    // A load on the boundary cycle lands in pending after the transfer above.
    if (disp_io.load) begin
      pend_d     = {disp_io.data, disp_io.dp, disp_io.digit_en, disp_io.lz_suppress};
      pend_vld_d = 1'b1;
    end
  end

  // Leading-zero mask: zero_above[i] set when nibbles DIGITS-1 down to i are all zero.
  always_comb begin
    zero_above = '0;
    all_zero   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero      = all_zero && (act_q.data[4*i +: 4] == 4'h0);
      zero_above[i] = all_zero;
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    cur_supp = 1'b0;
    sel_raw  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib    = act_q.data[4*i +: 4];
        cur_dp     = act_q.dp[i];
        cur_en     = act_q.en[i];
        cur_supp   = act_q.lz && zero_above[i] && (i != 0);
        sel_raw[i] = 1'b1;
      end
    end

    blank   = (32'(cnt_q) < BLANK_CYC);
    seg_raw = {cur_dp, cur_supp ? 7'h00 : hex7(cur_nib)};
    if (blank || !cur_en) begin
      seg_raw = 8'h00;
      sel_raw = '0;
    end

    seg_d   = seg_raw ^ SegOff;
    sel_d   = sel_raw ^ SelOff;
    fdone_d = frame_end;
  end

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SegOff;
      sel_q      <= SelOff;
      fdone_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      fdone_q    <= fdone_d;
    end
  end

  assign disp_io.seg        = seg_q;
  assign disp_io.sel        = sel_q;
  assign disp_io.frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: per-frame expectations checked by a frame monitor.
module tb_seg7_scan_driver;

  localparam int FrameCyc = 40;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS        (4),
    .SCAN_DIV      (10),
    .BLANK_CYC     (2),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_50m(clk),
    .rst    (rst),
    .disp_io(bus)
  );

  typedef struct packed {
    int          frame;
    logic [15:0] sel;   // {slot3, slot2, slot1, slot0}
    logic [31:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         frame_cnt = 0;
  int         frame_pos = -1;
  logic [3:0] sel_buf[FrameCyc];
  logic [7:0] seg_buf[FrameCyc];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_frame(input int f);
    exp_t       e;
    logic [3:0] bs;
    logic [7:0] bg;
    for (int s = 0; s < 4; s++) begin
      bs = sel_buf[s*10];
      bg = seg_buf[s*10];
      for (int c = 0; c < 2; c++) begin
        if (sel_buf[s*10+c] !== 4'hF || seg_buf[s*10+c] !== 8'hFF) begin
          bs = sel_buf[s*10+c];
          bg = seg_buf[s*10+c];
        end
      end
      check($sformatf("blank_f%0d_s%0d", f, s), {20'h0, bs, bg}, {20'h0, 4'hF, 8'hFF});
    end
    while (exp_q.size() > 0 && exp_q[0].frame < f) begin
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_frame: expectation for frame %0d unchecked, monitor at %0d", e.frame, f);
    end
    if (exp_q.size() > 0 && exp_q[0].frame == f) begin
      e = exp_q.pop_front();
      for (int s = 0; s < 4; s++) begin
        bs = sel_buf[s*10+2];
        bg = seg_buf[s*10+2];
        for (int c = 2; c < 10; c++) begin
          if (sel_buf[s*10+c] !== e.sel[4*s +: 4] || seg_buf[s*10+c] !== e.seg[8*s +: 8]) begin
            bs = sel_buf[s*10+c];
            bg = seg_buf[s*10+c];
          end
        end
        check($sformatf("lit_f%0d_s%0d", f, s), {20'h0, bs, bg},
              {20'h0, e.sel[4*s +: 4], e.seg[8*s +: 8]});
      end
    end
  endtask

  // Monitor: collects one 40-cycle frame between frame_done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        frame_pos = -1;
      end else begin
        if (frame_pos >= 0) begin
          if (frame_pos < FrameCyc) begin
            sel_buf[frame_pos] = bus.sel;
            seg_buf[frame_pos] = bus.seg;
          end
          frame_pos++;
        end
        if (bus.frame_done) begin
          if (frame_pos >= 0) begin
            check("frame_period", 32'(frame_pos), 32'(FrameCyc));
            if (frame_pos == FrameCyc) check_frame(frame_cnt);
          end
          frame_cnt++;
          frame_pos = 0;
        end
      end
    end
  end

  task automatic finish_now(input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired waiting on DUT", why);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic sync_frame();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_done) return;
    end
    finish_now("frame_done_timeout");
  endtask

  // Returns number of the frame now starting; a load issued next shows in frame n+1.
  task automatic start_frame(output int n);
    sync_frame();
    @(posedge clk);
    #1;
    n = frame_cnt;
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] en,
                          input logic lz);
    bus.data        = d;
    bus.dp          = dpv;
    bus.digit_en    = en;
    bus.lz_suppress = lz;
    bus.load        = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic push_exp(input int f, input logic [15:0] sel, input logic [31:0] seg);
    exp_t e;
    e.frame = f;
    e.sel   = sel;
    e.seg   = seg;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    finish_now("drain_timeout");
  endtask

  localparam logic [15:0] SelAll  = 16'h7BDE;
  localparam logic [15:0] SelDark = 16'hFFFF;
  localparam logic [31:0] SegDark = 32'hFFFF_FFFF;

  initial begin
    int n;
    int k;
    bus.data        = '0;
    bus.dp          = '0;
    bus.digit_en    = '0;
    bus.lz_suppress = 1'b0;
    bus.load        = 1'b0;
    rst             = 1'b1;
    #2 rst = 1'b0;
    #3;
    check("reset_sel", {28'h0, bus.sel}, 32'hF);
    check("reset_seg", {24'h0, bus.seg}, 32'hFF);
    check("reset_frame_done", {31'h0, bus.frame_done}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Dark until a load, then 12AF held across several free-running frames.
    start_frame(n);
    push_exp(n, SelDark, SegDark);
    load_val(16'h12AF, 4'h0, 4'hF, 1'b0);
    push_exp(n + 1, SelAll, 32'hF9A4_888E);
    push_exp(n + 2, SelAll, 32'hF9A4_888E);
    push_exp(n + 3, SelAll, 32'hF9A4_888E);
    drain();

    // Leading-zero suppression with a dp on a suppressed digit.
    start_frame(n);
    load_val(16'h0050, 4'b0100, 4'hF, 1'b1);
    push_exp(n + 1, SelAll, 32'hFF7F_92C0);
    drain();

    // Second load coincides with the frame boundary.
    start_frame(n);
    load_val(16'h1111, 4'h0, 4'hF, 1'b0);
    repeat (37) @(posedge clk);
    #1;
    load_val(16'h2222, 4'h0, 4'hF, 1'b0);
    push_exp(n + 1, SelAll, 32'hF9F9_F9F9);
    push_exp(n + 2, SelAll, 32'hA4A4_A4A4);
    drain();

    // Two loads in one frame (last wins) with digits 0 and 2 disabled.
    start_frame(n);
    load_val(16'h9999, 4'h0, 4'hF, 1'b0);
    load_val(16'h4321, 4'h0, 4'b1010, 1'b0);
    push_exp(n + 1, 16'h7FDF, 32'h99FF_A4FF);
    push_exp(n + 2, 16'h7FDF, 32'h99FF_A4FF);
    drain();

    // Asynchronous reset in the middle of slot 2 (display showing the 4321 pattern).
    start_frame(n);
    repeat (24) @(posedge clk);
    #5 rst = 1'b0;
    #1;
    check("midreset_sel", {28'h0, bus.sel}, 32'hF);
    check("midreset_seg", {24'h0, bus.seg}, 32'hFF);
    check("midreset_frame_done", {31'h0, bus.frame_done}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.frame_done) break;
    end
    check("restart_first_frame_done", 32'(k), 32'd40);
    @(posedge clk);
    #1;
    n = frame_cnt;
    push_exp(n, SelDark, SegDark);
    load_val(16'h8888, 4'h0, 4'hF, 1'b0);
    push_exp(n + 1, SelAll, 32'h8080_8080);
    push_exp(n + 2, SelAll, 32'h8080_8080);
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumer end of the display-scan timebase: multiplexes a DIGITS-wide hex value onto a common-segment 7-segment display.
- Runs entirely on clk_50m; an internal slot counter replaces any derived scan clock.
- Drives one-hot digit selects and segment lines, with dead-time blanking, leading-zero suppression and tear-free frame-boundary updates.

Parameters:
- DIGITS, 8: number of digits; DIGITS >= 2.
- SCAN_DIV, 125000: clk_50m cycles per digit slot (400 Hz per slot).
- BLANK_CYC, 2500: cycles at the start of each slot with all selects inactive; 0 <= BLANK_CYC < SCAN_DIV.
- SEG_ACTIVE_LOW, 1: 1 means segment lit = 0.
- SEL_ACTIVE_LOW, 1: 1 means digit selected = 0.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-low.
- data  in  4*DIGITS  hex nibbles; nibble i = data[4i+3:4i]; digit 0 is least significant (rightmost).
- dp  in  DIGITS  decimal point per digit.
- digit_en  in  DIGITS  per-digit enable; 0 = digit permanently dark.
- lz_suppress  in  1  leading-zero suppression enable.
- load  in  1  single-cycle strobe that captures data, dp, digit_en and lz_suppress.
- seg  out  8  segments: bit 0..6 = a..g, bit 7 = dp.
- sel  out  DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Reset is asynchronous, active-low, on clock clk_50m. In reset:
  - cnt = 0, idx = 0.
  - pending, active and pending_valid = 0.
  - seg = all unlit; sel = all inactive; frame_done = 0.
- Slot counter cnt runs 0..SCAN_DIV-1. At cnt == SCAN_DIV-1:
  - cnt <= 0.
  - idx <= (idx == DIGITS-1) ? 0 : idx+1.
- Frame boundary is the cycle with cnt == SCAN_DIV-1 and idx == DIGITS-1. At that cycle:
  - frame_done is registered high for exactly the next cycle.
  - If pending_valid, then active <= pending (the pre-edge value) and pending_valid <= 0.
- load:
  - Captures inputs into pending and sets pending_valid on the same edge.
  - Load coincident with the frame boundary: the new load goes into pending and pending_valid stays 1; the transfer uses the old pending. The new value is shown from the following frame.
  - Multiple loads within one frame: the last one wins.
  - Latency: a value loaded at cycle T is first driven in the slot for idx 0 after the next frame boundary.
- Outputs are registered from the pre-edge cnt/idx, so seg/sel lag cnt/idx by 1 cycle.
  - cnt < BLANK_CYC: sel all inactive, seg all unlit (anti-ghosting dead time).
  - Otherwise: sel asserts bit idx only; seg = decode(active nibble idx) plus dp bit.
- Hex decode, standard segment patterns (a..g, bit0 = a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero suppression (active lz_suppress):
  - Digit i > 0 is suppressed when active nibbles DIGITS-1 down to i are all zero. Suppressed digit: segments a..g unlit; dp still follows dp[i].
  - Digit 0 is never suppressed.
  - Digits disabled by digit_en still count as zero for this test when their nibble is 0.
- digit_en[i] = 0: sel stays inactive and seg stays unlit for the whole slot i. Slot timing is unchanged; no skipping.
- Polarity is applied at the output register only:
  - SEG_ACTIVE_LOW inverts all 8 seg bits.
  - SEL_ACTIVE_LOW inverts all sel bits.
- Reset deasserted mid-frame restarts the scan at idx 0, cnt 0, with a blank display until the first load has propagated.

Test Plan:
(Sim parameters: DIGITS=4, SCAN_DIV=10, BLANK_CYC=2, both polarities active-low.)
1. Reset, then load data=16'h12AF, dp=0, en=F, lz=0 -> after the next frame boundary:
   - slot 0: sel=4'b1110, seg=~8'h71; slot 3: sel=4'b0111, seg=~8'h06.
   - First 2 cycles of every slot: sel=4'hF, seg=8'hFF.
2. Free-run 3 frames -> frame_done high exactly 1 cycle every 40 cycles, and 1 cycle after cnt=9/idx=3.
3. load 16'h0050, lz=1, dp=4'b0100:
   - digit 3 blank, seg=8'hFF.
   - digit 2 seg=~8'h80 (dp only).
   - digit 1 = ~8'h6D; digit 0 = ~8'h3F.
4. load 16'h1111, then a second load of 16'h2222 at the frame-boundary cycle -> next frame shows 1111, the frame after shows 2222.
5. digit_en=4'b1010 -> sel bits 0 and 2 never asserted; slot timing unchanged (10 cycles per slot).
6. Assert rst mid-slot 2 -> outputs unlit/inactive immediately (asynchronous). After release: idx=0, display dark until a new load and frame boundary.
